fan_pwm_ctrl_multi: RTL
=======================

Name: fan_pwm_ctrl_multi

Overview:
- Multi-channel PWM fan/actuator controller for FPGA targets; parametrised successor of the single-channel switch-driven fan controller.
- Each channel has a programmable duty target, glitch-free period-aligned updates, soft-start ramping and a failsafe on disable.
- Optional tachometer measurement per channel.
- Sits in the FPGA top level on soc_clk; duty targets come from board switches or a register interface.

Parameters:
- NumChannels, 2, number of independent PWM channels.
- CntWidth, 8, PWM resolution in bits; period = 2^CntWidth ticks.
- PrescaleDiv, 20, clk_i cycles per PWM tick; must be >= 1; 1 means a tick every cycle.
- RampStep, 1, maximum upward duty change per PWM period.
- TachWindow, 50000000, clk_i cycles per tach measurement window; must be >= 2.
- TachWidth, 16, width of each tach count.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- en_i  in  1  global enable; low = failsafe.
- duty_i  in  NumChannels*CntWidth  per-channel duty targets; channel c at [c*CntWidth +: CntWidth].
- duty_valid_i  in  NumChannels  per-channel load strobe.
- pwm_o  out  NumChannels  PWM outputs.
- ramping_o  out  NumChannels  high while current duty < target.
- tach_i  in  NumChannels  asynchronous tach pulses.
- tach_cnt_o  out  NumChannels*TachWidth  edges counted in the last window.
- tach_valid_o  out  1  one-cycle pulse when tach_cnt_o updates.

Behaviour:
- Reset (rst_i=1 at a clk_i edge) clears: prescaler, PWM counter, cur_duty[c], target[c], pwm_o, ramping_o, tach_cnt_o, tach_valid_o and the tach window counter. Reset mid-period aborts the period immediately.
- Prescaler:
  - Counts 0..PrescaleDiv-1.
  - tick=1 in the cycle the count equals PrescaleDiv-1, then the count wraps to 0.
- PWM counter:
  - CntWidth bits; increments on tick and wraps from 2^CntWidth-1 to 0.
  - period_end = tick && (cnt == all-ones).
- Target load: duty_valid_i[c]=1 loads target[c] <= duty_i slice in the same cycle. Always accepted, no back-pressure. The last strobe before period_end wins.
- Duty update happens only on period_end, so there are no mid-period glitches. At each period_end:
  - If cur < target: cur <= min(cur+RampStep, target). Compute at CntWidth+1 bits and saturate.
  - If cur > target: cur <= target immediately (no down-ramp).
  - If cur == target: cur is unchanged.
- ramping_o[c] = registered (cur[c] < target[c]).
- Output:
  - pwm_o[c] is registered as (cnt < cur[c]), giving 1 cycle latency after the counter.
  - Duty 0 gives a constant low output.
  - Duty all-ones gives (2^CntWidth-1)/2^CntWidth high. There is no 100% mode in normal operation.
- Failsafe (en_i=0):
  - pwm_o = all ones from the next cycle.
  - Prescaler and PWM counter held at 0; cur_duty forced to 0; target retained.
  - On re-enable the counter starts at 0 and cur ramps up from 0 (soft-start).
- Simultaneous duty_valid_i and period_end on a channel: the ramp compare uses the old target; the new target takes effect at the next period_end.

Optional Feature:
- Macro: FAN_PWM_TACH_EN.
- Defined:
  - Each tach_i goes through a 2-flop synchroniser, then a rising-edge detector.
  - A per-channel edge counter saturates at all-ones.
  - The window counter runs 0..TachWindow-1. At the last cycle of the window:
    - tach_cnt_o <= counts, including an edge detected in that same cycle;
    - counters clear;
    - tach_valid_o pulses for 1 cycle.
  - The window keeps running while en_i=0.
- Undefined: tach_i is ignored, and tach_cnt_o and tach_valid_o are tied to 0. No tach logic is synthesised.

Test Plan:
- CntWidth=4, PrescaleDiv=2, RampStep=16, target 4 on ch0 -> after the first period_end, pwm_o[0] is high 8 cycles of each 32-cycle period; ch1 stays low.
- RampStep=1, target 0->10 -> ramping_o=1 for 10 periods; cur increments by 1 per period; ramping_o drops when cur=10.
- Change target 10->3 mid-period -> pwm_o width unchanged until the period ends, then immediately 6 of 32 cycles; no ramp.
- en_i 1->0 mid-period -> all pwm_o=1 from the next cycle. en_i->1 -> pwm_o low at cnt=0 and duty re-ramps from 0.
- FAN_PWM_TACH_EN, TachWindow=100, 7 tach pulses of 3 cycles each -> tach_cnt_o=7 with a 1-cycle tach_valid_o at cycle 100. With TachWidth=2 and 7 pulses -> saturates at 3.
- Assert rst_i mid-ramp with duty_valid_i asserted -> all outputs 0 the next cycle; the target load is discarded.

Source files
------------

// File: rtl/fan_pwm_ctrl_multi.sv
// ---------------------------------------------------------------------------
// fan_pwm_ctrl_multi
//
// Multi-channel PWM fan/actuator controller.
//
// Each channel has a programmable duty target. The duty actually driven only
// changes at the end of a PWM period, so the output never glitches. The duty
// ramps up toward the target (soft-start), drops to a lower target at once,
// and every output goes fully on while the global enable is low (failsafe).
//
// Optional feature macro: FAN_PWM_TACH_EN
//   defined   : per-channel tachometer edge counting over a fixed window
//   undefined : tach_i is ignored, tach_cnt_o / tach_valid_o are tied to 0
//
// Ports:
//   clk_i         clock (soc_clk)
//   rst_i         synchronous active-high reset
//   en_i          global enable, low = failsafe (all PWM outputs high)
//   duty_i        per-channel duty targets, channel c at [c*CntWidth +: CntWidth]
//   duty_valid_i  per-channel target load strobe
//   pwm_o         per-channel PWM outputs (registered)
//   ramping_o     per-channel "current duty below target" (registered)
//   tach_i        per-channel asynchronous tach pulses
//   tach_cnt_o    per-channel rising-edge counts of the last window
//   tach_valid_o  one-cycle pulse when tach_cnt_o updates
// ---------------------------------------------------------------------------
module fan_pwm_ctrl_multi #(
    parameter int NumChannels = 2,
    parameter int CntWidth    = 8,
    parameter int PrescaleDiv = 20,
    parameter int RampStep    = 1,
    parameter int TachWindow  = 50000000,
    parameter int TachWidth   = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            en_i,
    input  logic [NumChannels*CntWidth-1:0] duty_i,
    input  logic [NumChannels-1:0]          duty_valid_i,
    output logic [NumChannels-1:0]          pwm_o,
    output logic [NumChannels-1:0]          ramping_o,
    input  logic [NumChannels-1:0]          tach_i,
    output logic [NumChannels*TachWidth-1:0] tach_cnt_o,
    output logic                            tach_valid_o
);

    // Prescaler width; a divide of 1 still needs one (constant-zero) bit.
    localparam int              PreW      = (PrescaleDiv > 1) ? $clog2(PrescaleDiv) : 1;
    localparam logic [PreW-1:0] PreLast   = PreW'(PrescaleDiv - 1);
    // A step larger than the full range behaves like the full range.
    localparam int              RampClamp = (RampStep > (2 ** CntWidth)) ? (2 ** CntWidth) : RampStep;
    localparam logic [CntWidth:0] RampInc = (CntWidth + 1)'(RampClamp);

    logic [PreW-1:0]                         r_pre;
    logic [CntWidth-1:0]                     r_cnt;
    logic [NumChannels-1:0][CntWidth-1:0]    r_cur;
    logic [NumChannels-1:0][CntWidth-1:0]    r_target;
    logic [NumChannels-1:0]                  r_pwm;
    logic [NumChannels-1:0]                  r_ramping;
    logic                                    w_tick;
    logic                                    w_period_end;

    // Next duty at a period boundary: saturating ramp up, immediate drop down.
    function automatic logic [CntWidth-1:0] ramp_next(
        input logic [CntWidth-1:0] cur,
        input logic [CntWidth-1:0] tgt
    );
        logic [CntWidth:0] w_sum;
        w_sum = {1'b0, cur} + RampInc;
        if (cur > tgt) begin
            ramp_next = tgt;
        end else if (w_sum > {1'b0, tgt}) begin
            ramp_next = tgt;
        end else begin
            ramp_next = w_sum[CntWidth-1:0];
        end
    endfunction

    assign w_tick       = (r_pre == PreLast);
    assign w_period_end = w_tick && (r_cnt == '1);

    // Prescaler: counts 0..PrescaleDiv-1, parked at 0 during failsafe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pre <= '0;
        end else if (!en_i) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // PWM period counter: advances once per tick, wraps naturally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (!en_i) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Per-channel target/duty/output state. Targets load on their strobe;
    // the ramp compare at a period end sees the target from before this edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cur     <= '0;
            r_target  <= '0;
            r_pwm     <= '0;
            r_ramping <= '0;
        end else begin
            for (int c = 0; c < NumChannels; c++) begin
                if (duty_valid_i[c]) begin
                    r_target[c] <= duty_i[c*CntWidth +: CntWidth];
                end else begin
                    r_target[c] <= r_target[c];
                end
                if (!en_i) begin
                    r_cur[c] <= '0;
                    r_pwm[c] <= 1'b1;
                end else begin
                    if (w_period_end) begin
                        r_cur[c] <= ramp_next(r_cur[c], r_target[c]);
                    end else begin
                        r_cur[c] <= r_cur[c];
                    end
                    r_pwm[c] <= (r_cnt < r_cur[c]);
                end
                r_ramping[c] <= (r_cur[c] < r_target[c]);
            end
        end
    end

    assign pwm_o     = r_pwm;
    assign ramping_o = r_ramping;

`ifdef FAN_PWM_TACH_EN
    localparam int               TwW     = $clog2(TachWindow);
    localparam logic [TwW-1:0]   WinLast = TwW'(TachWindow - 1);

    logic [NumChannels-1:0]                r_tach_meta;
    logic [NumChannels-1:0]                r_tach_sync;
    logic [NumChannels-1:0]                r_tach_prev;
    logic [NumChannels-1:0][TachWidth-1:0] r_tach_acc;
    logic [NumChannels-1:0][TachWidth-1:0] r_tach_cnt;
    logic [TwW-1:0]                        r_win;
    logic                                  r_tach_valid;
    logic [NumChannels-1:0]                w_tach_rise;
    logic                                  w_win_last;

    // Saturating increment so a fast tach never wraps to a small count.
    function automatic logic [TachWidth-1:0] sat_inc(
        input logic [TachWidth-1:0] cnt,
        input logic                 inc
    );
        if (inc && (cnt != '1)) begin
            sat_inc = cnt + 1'b1;
        end else begin
            sat_inc = cnt;
        end
    endfunction

    assign w_tach_rise = r_tach_sync & ~r_tach_prev;
    assign w_win_last  = (r_win == WinLast);

    // Tach synchroniser, edge counting and window publish; independent of en_i.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tach_meta  <= '0;
            r_tach_sync  <= '0;
            r_tach_prev  <= '0;
            r_tach_acc   <= '0;
            r_tach_cnt   <= '0;
            r_win        <= '0;
            r_tach_valid <= 1'b0;
        end else begin
            r_tach_meta <= tach_i;
            r_tach_sync <= r_tach_meta;
            r_tach_prev <= r_tach_sync;
            if (w_win_last) begin
                r_win        <= '0;
                r_tach_valid <= 1'b1;
                for (int c = 0; c < NumChannels; c++) begin
                    // An edge seen in the window's last cycle still belongs to it.
                    r_tach_cnt[c] <= sat_inc(r_tach_acc[c], w_tach_rise[c]);
                    r_tach_acc[c] <= '0;
                end
            end else begin
                r_win        <= r_win + 1'b1;
                r_tach_valid <= 1'b0;
                for (int c = 0; c < NumChannels; c++) begin
                    r_tach_cnt[c] <= r_tach_cnt[c];
                    r_tach_acc[c] <= sat_inc(r_tach_acc[c], w_tach_rise[c]);
                end
            end
        end
    end

    assign tach_cnt_o   = r_tach_cnt;
    assign tach_valid_o = r_tach_valid;
`else
    logic w_unused_tach;

    assign w_unused_tach = ^{tach_i, TachWindow[0]};
    assign tach_cnt_o    = '0;
    assign tach_valid_o  = 1'b0;
`endif

endmodule
